pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of PC, d, offset, q and bus_out.
REQ-002 Parameter RESET_VAL, default 0, PC value after reset.
REQ-003 Parameter STEP, default 1, increment applied by inc.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2); only meaningful with PC_RAS_EN.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 stall  input  1  hold PC and stack this cycle.
REQ-009 load  input  1  absolute load: PC <= d.
REQ-010 call  input  1  push current PC to stack, PC <= d.
REQ-011 ret  input  1  pop stack top into PC.
REQ-012 branch  input  1  relative: PC <= PC + offset.
REQ-013 inc  input  1  PC <= PC + STEP.
REQ-014 enable_out  input  1  drive PC onto bus_out.
REQ-015 d  input  WIDTH  absolute target from bus.
REQ-016 offset  input  WIDTH  two's-complement branch displacement, pre-sign-extended.
REQ-017 q  output  WIDTH  registered PC.
REQ-018 bus_out  output  WIDTH  q when enable_out=1, else all zeros.
REQ-019 ras_empty  output  1  stack holds zero entries.
REQ-020 ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-021 ras_err  output  1  sticky stack overflow/underflow flag.

Function
REQ-022 All PC and stack updates SHALL occur on the rising clk edge; q reflects the update one cycle after the command is sampled.
REQ-023 bus_out SHALL be combinational from q and enable_out, with no added latency.
REQ-024 Command priority SHALL be reset > stall > load > call > ret > branch > inc; lower-priority commands asserted the same cycle are ignored.
REQ-025 With no command asserted, PC and stack SHALL hold.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; inc from all-ones wraps to 0; branch wraps in both directions.
REQ-027 The pushed return address SHALL be the current q (pre-update value).
REQ-028 call when stack full SHALL overwrite the oldest entry (circular), keep ras_full=1, and set ras_err.
REQ-029 ret when stack empty SHALL leave PC and stack unchanged and set ras_err.
REQ-030 ras_err SHALL clear only on reset.
REQ-031 ras_empty/ras_full SHALL be registered-consistent with the stack count after each edge.

Reset
REQ-032 On reset: q=RESET_VAL, stack count=0, ras_empty=1, ras_full=0, ras_err=0; stack contents are don't-care.
REQ-033 reset mid-sequence (e.g. with call asserted) SHALL discard the command entirely.

Configuration
REQ-034 Macro PC_RAS_EN SHALL compile in the return-address stack.
REQ-035 Without PC_RAS_EN: call behaves as load (no push); ret is ignored (PC holds); ras_empty=1, ras_full=0, ras_err=0 constant; no stack storage is instantiated.

Verification
REQ-036 Reset then inc x3, WIDTH=32, STEP=1 -> q=0,1,2,3; bus_out=3 with enable_out=1, 0 with enable_out=0.
REQ-037 q=0xFFFFFFFF, inc -> q=0; q=0x10, branch offset=0xFFFFFFF0 -> q=0.
REQ-038 load d=0x100 with inc and branch asserted -> q=0x100; stall+load -> q unchanged.
REQ-039 (PC_RAS_EN, DEPTH=4) q=0x20, call d=0x80 -> q=0x80, ras_empty=0; ret -> q=0x20, ras_empty=1.
REQ-040 (PC_RAS_EN, DEPTH=4) 5 calls from q=1,2,3,4,5 -> ras_err=1, ras_full=1; 4 rets -> q=5,4,3,2; 5th ret -> q holds at 2.
REQ-041 (no PC_RAS_EN) call d=0x40 -> q=0x40; ret -> q=0x40; ras_empty=1, ras_err=0 throughout.

Source files
------------

// File: rtl/pc_unit_if.sv
// Command/status bundle for pc_unit: the master drives the PC commands and the
// slave (pc_unit) returns the PC, the gated bus copy and the stack flags.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             load;
  logic             call;
  logic             ret;
  logic             branch;
  logic             inc;
  logic             enable_out;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] bus_out;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

  modport master (
    output stall, load, call, ret, branch, inc, enable_out, d, offset,
    input  q, bus_out, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, load, call, ret, branch, inc, enable_out, d, offset,
    output q, bus_out, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with prioritised load/call/ret/branch/inc commands.
// Define PC_RAS_EN to build in the circular return-address stack.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] STEP      = 1,
  parameter int               RAS_DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_unit: RAS_DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] q_q, q_d;

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic             do_call, do_ret;
  logic [WIDTH-1:0] ret_addr;

  assign ret_addr = ras_mem[sp_q - PTR_W'(1)];
`endif

  always_comb begin
    q_d = q_q;
`ifdef PC_RAS_EN
    do_call = 1'b0;
    do_ret  = 1'b0;
`endif
    if (!bus.stall) begin
      if (bus.load) begin
        q_d = bus.d;
      end else if (bus.call) begin
        q_d = bus.d;
`ifdef PC_RAS_EN
        do_call = 1'b1;
`endif
      end else if (bus.ret) begin
        // ret still outranks branch/inc even when it cannot change the PC
`ifdef PC_RAS_EN
        do_ret = 1'b1;
        if (!empty_q) q_d = ret_addr;
`endif
      end else if (bus.branch) begin
        q_d = q_q + bus.offset;
      end else if (bus.inc) begin
        q_d = q_q + STEP;
      end
    end
  end

`ifdef PC_RAS_EN
  // sp points at the next free slot; when full it points at the oldest entry,
  // so a push simply overwrites it.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (do_call) begin
      sp_d = sp_q + PTR_W'(1);
      if (full_q) err_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end else if (do_ret) begin
      if (empty_q) begin
        err_d = 1'b1;
      end else begin
        sp_d  = sp_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_W'(RAS_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset && do_call) ras_mem[sp_q] <= q_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign bus.ras_empty = empty_q;
  assign bus.ras_full  = full_q;
  assign bus.ras_err   = err_q;
`else
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) q_q <= RESET_VAL;
    else       q_q <= q_d;
  end

  assign bus.q       = q_q;
  assign bus.bus_out = bus.enable_out ? q_q : '0;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes hand-computed expectations,
// a monitor pops and compares one vector per clock edge.
module tb_pc_unit;
  localparam int W = 32;

  localparam logic [7:0] C_RST  = 8'h80;
  localparam logic [7:0] C_STL  = 8'h40;
  localparam logic [7:0] C_LD   = 8'h20;
  localparam logic [7:0] C_CALL = 8'h10;
  localparam logic [7:0] C_RET  = 8'h08;
  localparam logic [7:0] C_BR   = 8'h04;
  localparam logic [7:0] C_INC  = 8'h02;
  localparam logic [7:0] C_EN   = 8'h01;

  // flags are {ras_empty, ras_full, ras_err}
  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_E    = 3'b100;
  localparam logic [2:0] F_F    = 3'b010;
  localparam logic [2:0] F_R    = 3'b001;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic [W-1:0] bus_out;
    logic [2:0]   flags;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(W)) bus ();

  pc_unit #(
    .WIDTH    (W),
    .RESET_VAL(32'h0),
    .STEP     (32'h1),
    .RAS_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic apply(input string name, input logic [7:0] cmd,
                       input logic [W-1:0] d, input logic [W-1:0] off,
                       input logic [W-1:0] exp_q, input logic [2:0] exp_flags);
    exp_t e;
    @(negedge clk);
    reset          = cmd[7];
    bus.stall      = cmd[6];
    bus.load       = cmd[5];
    bus.call       = cmd[4];
    bus.ret        = cmd[3];
    bus.branch     = cmd[2];
    bus.inc        = cmd[1];
    bus.enable_out = cmd[0];
    bus.d          = d;
    bus.offset     = off;
    e.name    = name;
    e.q       = exp_q;
    e.bus_out = cmd[0] ? exp_q : '0;
    e.flags   = exp_flags;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [2:0] flags;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        flags = {bus.ras_empty, bus.ras_full, bus.ras_err};
        n_vec++;
        if (bus.q !== e.q || bus.bus_out !== e.bus_out || flags !== e.flags) begin
          n_err++;
          $display("FAIL %s: got q=%h bus_out=%h flags=%b, expected q=%h bus_out=%h flags=%b",
                   e.name, bus.q, bus.bus_out, flags, e.q, e.bus_out, e.flags);
        end else begin
          $display("ok   %s: q=%h bus_out=%h flags=%b", e.name, bus.q, bus.bus_out, flags);
        end
      end
    end
  end

  initial begin : stimulus
    int waited;
    reset = 1'b1;
    bus.stall = 1'b0; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.branch = 1'b0; bus.inc = 1'b0; bus.enable_out = 1'b0;
    bus.d = '0; bus.offset = '0;

    apply("reset",        C_RST | C_EN,                32'h0,        32'h0,        32'h0,        F_E);
    apply("inc1",         C_INC | C_EN,                32'h0,        32'h0,        32'h1,        F_E);
    apply("inc2",         C_INC | C_EN,                32'h0,        32'h0,        32'h2,        F_E);
    apply("inc3",         C_INC | C_EN,                32'h0,        32'h0,        32'h3,        F_E);
    apply("hold_en",      C_EN,                        32'h0,        32'h0,        32'h3,        F_E);
    apply("hold_dis",     8'h00,                       32'h0,        32'h0,        32'h3,        F_E);
    apply("load_ones",    C_LD | C_EN,                 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, F_E);
    apply("inc_wrap",     C_INC | C_EN,                32'h0,        32'h0,        32'h0,        F_E);
    apply("load_10",      C_LD | C_EN,                 32'h10,       32'h0,        32'h10,       F_E);
    apply("br_back",      C_BR | C_EN,                 32'h0,        32'hFFFFFFF0, 32'h0,        F_E);
    apply("br_neg_wrap",  C_BR | C_EN,                 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, F_E);
    apply("br_fwd_wrap",  C_BR | C_EN,                 32'h0,        32'h1,        32'h0,        F_E);
    apply("load_prio",    C_LD | C_INC | C_BR | C_EN,  32'h100,      32'h8,        32'h100,      F_E);
    apply("stall_load",   C_STL | C_LD | C_EN,         32'h55,       32'h0,        32'h100,      F_E);
    apply("stall_inc",    C_STL | C_INC | C_EN,        32'h0,        32'h0,        32'h100,      F_E);
    apply("br_over_inc",  C_BR | C_INC | C_EN,         32'h0,        32'h10,       32'h110,      F_E);
    apply("reset_load",   C_RST | C_LD | C_EN,         32'h77,       32'h0,        32'h0,        F_E);

`ifdef PC_RAS_EN
    apply("load_20",      C_LD | C_EN,                 32'h20,       32'h0,        32'h20,       F_E);
    apply("call_80",      C_CALL | C_EN,               32'h80,       32'h0,        32'h80,       F_NONE);
    apply("ret_20",       C_RET | C_EN,                32'h0,        32'h0,        32'h20,       F_E);
    apply("load_1",       C_LD | C_EN,                 32'h1,        32'h0,        32'h1,        F_E);
    apply("call_a",       C_CALL | C_EN,               32'h2,        32'h0,        32'h2,        F_NONE);
    apply("call_b",       C_CALL | C_EN,               32'h3,        32'h0,        32'h3,        F_NONE);
    apply("call_c",       C_CALL | C_EN,               32'h4,        32'h0,        32'h4,        F_NONE);
    apply("call_full",    C_CALL | C_EN,               32'h5,        32'h0,        32'h5,        F_F);
    apply("call_over",    C_CALL | C_EN,               32'h6,        32'h0,        32'h6,        F_F | F_R);
    apply("ret_5",        C_RET | C_EN,                32'h0,        32'h0,        32'h5,        F_R);
    apply("ret_4",        C_RET | C_EN,                32'h0,        32'h0,        32'h4,        F_R);
    apply("ret_3",        C_RET | C_EN,                32'h0,        32'h0,        32'h3,        F_R);
    apply("ret_2",        C_RET | C_EN,                32'h0,        32'h0,        32'h2,        F_E | F_R);
    apply("ret_under",    C_RET | C_EN,                32'h0,        32'h0,        32'h2,        F_E | F_R);
    apply("ret_over_br",  C_RET | C_BR | C_EN,         32'h0,        32'h8,        32'h2,        F_E | F_R);
    apply("reset_call",   C_RST | C_CALL | C_EN,       32'h99,       32'h0,        32'h0,        F_E);
    apply("load_over_call", C_LD | C_CALL | C_EN,      32'h30,       32'h0,        32'h30,       F_E);
    apply("call_over_ret", C_CALL | C_RET | C_EN,      32'h44,       32'h0,        32'h44,       F_NONE);
    apply("ret_30",       C_RET | C_BR | C_EN,         32'h0,        32'h4,        32'h30,       F_E);
    apply("stall_call",   C_STL | C_CALL | C_EN,       32'h66,       32'h0,        32'h30,       F_E);
`else
    apply("load_20",      C_LD | C_EN,                 32'h20,       32'h0,        32'h20,       F_E);
    apply("call_as_load", C_CALL | C_EN,               32'h40,       32'h0,        32'h40,       F_E);
    apply("ret_ignored",  C_RET | C_EN,                32'h0,        32'h0,        32'h40,       F_E);
    apply("ret_again",    C_RET,                       32'h0,        32'h0,        32'h40,       F_E);
    apply("load_over_call", C_LD | C_CALL | C_EN,      32'h50,       32'h0,        32'h50,       F_E);
    apply("stall_call",   C_STL | C_CALL | C_EN,       32'h66,       32'h0,        32'h50,       F_E);
`endif

    @(negedge clk);
    reset = 1'b0;
    bus.stall = 1'b0; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.branch = 1'b0; bus.inc = 1'b0;

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors still pending, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
